muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO R-type instructions and runs a 32-step shift-add multiply or restoring divide into the HI/LO architectural registers. While an operation is in flight it raises `stall` to the hazard unit for any dependent HI/LO access. It runs alongside the ALU and shares its `funct` decode constants.

## Interface
- `WIDTH`, 32: operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `valid`  in  1  R-type instruction present in EX; the unit considers `funct` only when `valid`=1.
- `funct`  in  6  R-type funct field.
- `a`  in  WIDTH  rs operand, multiplicand or dividend.
- `b`  in  WIDTH  rt operand, multiplier or divisor.
- `hi`  out  WIDTH  HI register; reset value 0.
- `lo`  out  WIDTH  LO register; reset value 0.
- `busy`  out  1  operation in flight; reset value 0.
- `stall`  out  1  combinational; the hazard unit must hold EX and everything upstream.
- `done`  out  1  one-cycle pulse after HI/LO take a new mult/div result; reset value 0.

## Operation
- Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. All other funct values are ignored.
- States:
  - IDLE: on valid MULT*/DIV*, latch the operation and operands and go to RUN.
  - RUN: execute 32 steps (count 0..31), then go to FIX.
  - FIX: write HI/LO and go to IDLE.
- Accept: a valid MULT*/DIV* in IDLE enters RUN. Signed ops (MULT, DIV) latch operand magnitudes plus sign bits `sa` and `sb`. Unsigned ops latch the raw operands.
- Multiply: 64-bit accumulator with shift-add on the multiplier LSB.
  - FIX negates the 64-bit product when signed and `sa`^`sb`.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring algorithm with a 33-bit partial remainder; one quotient bit per step.
  - FIX negates the quotient if `sa`^`sb`, and negates the remainder if `sa`.
  - LO = quotient, HI = remainder. Signed results truncate toward zero.
- Divide by zero (`b`=0 at accept): the unit skips RUN and goes IDLE→FIX. FIX writes LO=0xFFFFFFFF and HI=`a`.
- MTHI/MTLO in IDLE: write `a` to HI/LO at that edge. No `busy`, no `done`.
- MFHI/MFLO in IDLE: no stall. The pipeline reads `hi`/`lo` directly.
- `stall` = `valid` & `busy` & (funct ∈ {MF*, MT*, MULT*, DIV*}). Non-HI/LO instructions never stall.
- HI/LO hold their values during RUN. They change only in FIX or on MT*.

## Timing
- Accept edge E0: `busy`=1 from E0.
- RUN steps occupy edges E1..E32. FIX at E33 writes HI/LO, clears `busy` and sets `done` for cycle E33..E34.
- Total occupancy is 33 cycles; the first dependent MF* issues in the cycle after E33.
- Divide by zero: FIX at E1. `busy` is high for 1 cycle, then `done`.
- A HI/LO instruction presented during FIX is still stalled. It is accepted at the next edge, so back-to-back mult/div ops have a 1-cycle gap minimum.
- `reset` mid-operation aborts at that edge: state IDLE, count 0, HI=LO=0, `busy`=`done`=0. No partial result is written.
- `reset` has priority over every concurrent accept or MT* write.

## Structure
- Add the funct constants (`MULT`, `MULTU`, `DIV`, `DIVU`, `MFHI`, `MFLO`, `MTHI`, `MTLO`) to the shared Opcode header beside the existing R-type functs.
- State encoding (IDLE/RUN/FIX) and the iteration count are local to the block.
- One sub-module, `muldiv_core`:
  - Holds the accumulator/remainder registers, the step logic and the sign fix-up.
  - Driven by `load`, `step` and `fix` strobes from the sequencer FSM.
  - Returns 64-bit `result`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT a=-3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 → `busy` for 1 cycle, LO=0xFFFFFFFF, HI=100.
- MULT issued, then MFLO presented every cycle → `stall`=1 from E0 through the FIX cycle. MFLO sees the new LO the cycle after E33. An ADDU presented mid-RUN never stalls.
- MTHI a=0x12345678 in IDLE → HI=0x12345678 next cycle, `busy`=0. A MTLO during RUN stalls, then writes after completion.
- Assert `reset` at E10 of a DIVU → HI=LO=0 and `busy`=0 next cycle. A fresh MULTU 6×7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared R-type funct decode constants for the EX stage (ALU and the
// multiply/divide sequencer both import this), plus small decode helpers
// that classify the HI/LO family of instructions.
// No ports: package only.
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

   // Existing ALU R-type functs
   localparam logic [5:0] SLL   = 6'h00;
   localparam logic [5:0] SRL   = 6'h02;
   localparam logic [5:0] SRA   = 6'h03;
   localparam logic [5:0] JR    = 6'h08;
   localparam logic [5:0] ADD   = 6'h20;
   localparam logic [5:0] ADDU  = 6'h21;
   localparam logic [5:0] SUB   = 6'h22;
   localparam logic [5:0] SUBU  = 6'h23;
   localparam logic [5:0] AND   = 6'h24;
   localparam logic [5:0] OR    = 6'h25;
   localparam logic [5:0] XOR   = 6'h26;
   localparam logic [5:0] NOR   = 6'h27;
   localparam logic [5:0] SLT   = 6'h2A;
   localparam logic [5:0] SLTU  = 6'h2B;

   // HI/LO move and multiply/divide functs
   localparam logic [5:0] MFHI  = 6'h10;
   localparam logic [5:0] MTHI  = 6'h11;
   localparam logic [5:0] MFLO  = 6'h12;
   localparam logic [5:0] MTLO  = 6'h13;
   localparam logic [5:0] MULT  = 6'h18;
   localparam logic [5:0] MULTU = 6'h19;
   localparam logic [5:0] DIV   = 6'h1A;
   localparam logic [5:0] DIVU  = 6'h1B;

   // True for the four instructions that start an iterative operation
   function automatic logic is_muldiv(input logic [5:0] f);
      return (f == MULT) || (f == MULTU) || (f == DIV) || (f == DIVU);
   endfunction

   // True for the divide half of the family
   function automatic logic is_div(input logic [5:0] f);
      return (f == DIV) || (f == DIVU);
   endfunction

   // True for the signed variants, which work on operand magnitudes
   function automatic logic is_signed_op(input logic [5:0] f);
      return (f == MULT) || (f == DIV);
   endfunction

   // True for anything that reads or writes HI/LO and so must wait on a busy unit
   function automatic logic is_hilo(input logic [5:0] f);
      return is_muldiv(f) || (f == MFHI) || (f == MTHI) || (f == MFLO) || (f == MTLO);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
// Datapath for the iterative multiply/divide unit. Holds the working
// accumulator / partial remainder, performs one shift-add multiply step or
// one restoring divide step per strobe, and presents the sign-corrected
// 64-bit result (HI in the upper half, LO in the lower half).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   load          capture operands and operation type
//   step          perform one iteration
//   fix           result is being consumed this cycle; clear working state
//   is_div        operation at load is a divide
//   is_signed     operation at load is signed
//   a, b          operands (multiplicand/dividend, multiplier/divisor)
//   result        {HI, LO} after sign fix-up
// -----------------------------------------------------------------------------
module muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               fix,
   input  logic               is_div,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result
);

   logic [WIDTH:0]     upper;
   logic [WIDTH-1:0]   lower;
   logic [WIDTH-1:0]   operand;
   logic               div_op;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;

   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quo_fixed;
   logic [WIDTH-1:0]   rem_fixed;

   // Signed operations run on magnitudes; the sign bits are remembered so the
   // fix-up can restore them. The most negative value maps onto itself, which
   // is still the correct unsigned magnitude.
   always_comb begin
      sa    = is_signed & a[WIDTH-1];
      sb    = is_signed & b[WIDTH-1];
      mag_a = sa ? -a : a;
      mag_b = sb ? -b : b;
   end

   // One iteration of each algorithm. Multiply keeps {upper, lower} as a
   // combined accumulator whose low half initially holds the multiplier, so
   // the multiplier LSB is always lower[0]. Divide shifts the dividend out of
   // lower into the partial remainder and shifts quotient bits in behind it;
   // the extra top bit of div_diff is the borrow that decides restore or keep.
   always_comb begin
      mul_sum   = {1'b0, upper[WIDTH-1:0]} + (lower[0] ? {1'b0, operand} : '0);
      div_shift = {upper[WIDTH-1:0], lower[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, operand};
   end

   // Working registers. On load the multiply gets the multiplicand in operand
   // and the multiplier in lower; the divide gets the divisor in operand and
   // the dividend in lower. A zero divisor parks the raw dividend in lower so
   // it can be returned as HI untouched. After the result is consumed the
   // registers are cleared so an idle unit carries no stale operands.
   always_ff @(posedge clk) begin
      if (reset || fix) begin
         upper    <= '0;
         lower    <= '0;
         operand  <= '0;
         div_op   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else if (load) begin
         upper    <= '0;
         div_op   <= is_div;
         neg_q    <= sa ^ sb;
         neg_r    <= sa;
         div_zero <= is_div && (b == '0);
         operand  <= is_div ? mag_b : mag_a;
         if (is_div && (b == '0)) begin
            lower <= a;
         end else begin
            lower <= is_div ? mag_a : mag_b;
         end
      end else if (step) begin
         if (div_op) begin
            if (!div_diff[WIDTH+1]) begin
               upper <= div_diff[WIDTH:0];
               lower <= {lower[WIDTH-2:0], 1'b1};
            end else begin
               upper <= div_shift;
               lower <= {lower[WIDTH-2:0], 1'b0};
            end
         end else begin
            upper <= {1'b0, mul_sum[WIDTH:1]};
            lower <= {mul_sum[0], lower[WIDTH-1:1]};
         end
      end
   end

   // Sign fix-up. The product is negated as a whole; for divide the quotient
   // follows the operand signs and the remainder follows the dividend, which
   // gives truncation toward zero.
   always_comb begin
      product   = {upper[WIDTH-1:0], lower};
      quo_fixed = neg_q ? -lower : lower;
      rem_fixed = neg_r ? -upper[WIDTH-1:0] : upper[WIDTH-1:0];
      if (div_zero) begin
         result = {lower, {WIDTH{1'b1}}};
      end else if (div_op) begin
         result = {rem_fixed, quo_fixed};
      end else begin
         result = neg_q ? -product : product;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative multiply/divide sequencer for the EX stage. Owns the HI/LO
// architectural registers, accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO, runs
// a WIDTH-step operation in muldiv_core and stalls dependent HI/LO accesses
// while busy.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   valid        R-type instruction present in EX
//   funct        R-type funct field
//   a, b         rs / rt operands
//   hi, lo       HI and LO registers
//   busy         an operation is in flight
//   stall        hold EX and upstream (combinational)
//   done         one-cycle pulse after HI/LO take a mult/div result
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done
);

   import muldiv_sequencer_pkg::*;

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [CW-1:0]       count;
   logic                load;
   logic                step;
   logic                fix;
   logic                write_hi;
   logic                write_lo;
   logic [2*WIDTH-1:0]  result;

   // State register and iteration counter. The counter only advances in RUN
   // and is held at zero everywhere else, so it is ready for the next op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= next_state;
         if (step) begin
            count <= count + 1'b1;
         end else begin
            count <= '0;
         end
      end
   end

   // Next-state and strobes. A divide by zero has nothing to iterate, so it
   // goes straight to FIX, which then reports the fixed special result.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      fix        = 1'b0;
      case (state)
         IDLE: begin
            if (valid && is_muldiv(funct)) begin
               load       = 1'b1;
               next_state = (is_div(funct) && (b == '0)) ? FIX : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == CW'(WIDTH - 1)) begin
               next_state = FIX;
            end
         end
         FIX: begin
            fix        = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Status outputs. Busy covers RUN and FIX, so anything touching HI/LO
   // during the write-back cycle is still held and issues one edge later.
   always_comb begin
      busy     = (state != IDLE);
      stall    = valid && busy && is_hilo(funct);
      write_hi = valid && (state == IDLE) && (funct == MTHI);
      write_lo = valid && (state == IDLE) && (funct == MTLO);
   end

   muldiv_core #(
      .WIDTH     (WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .fix       (fix),
      .is_div    (is_div(funct)),
      .is_signed (is_signed_op(funct)),
      .a         (a),
      .b         (b),
      .result    (result)
   );

   // HI/LO only change on a completed operation or an MT* in IDLE; the two
   // can never coincide because FIX and IDLE are distinct states.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= fix;
         if (fix) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
         end else begin
            if (write_hi) begin
               hi <= a;
            end
            if (write_lo) begin
               lo <= a;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Expected HI/LO values come from a
// plain-arithmetic model of the instruction semantics; timing expectations
// come from the documented 33-cycle occupancy.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   import muldiv_sequencer_pkg::*;

   logic        clk;
   logic        reset;
   logic        valid;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;
   logic        done;

   int compared   = 0;
   int mismatched = 0;

   muldiv_sequencer #(
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .valid (valid),
      .funct (funct),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .stall (stall),
      .done  (done)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural result of a mult/div instruction as {HI, LO}
   function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      longint sx;
      longint sy;
      longint q;
      longint r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = '0;
      case (f)
         MULTU: p = {32'd0, x} * {32'd0, y};
         MULT: begin
            q = sx * sy;
            p = q;
         end
         DIVU: p = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         DIV: begin
            if (y == 32'd0) begin
               p = {x, 32'hFFFFFFFF};
            end else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   // Drive the EX-stage inputs
   task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] x,
                                input logic [31:0] y);
      valid = v;
      funct = f;
      a     = x;
      b     = y;
   endtask

   // Issue one op from a falling edge and wait (bounded) for done; reports the
   // number of falling edges up to done, busy cycles seen, and done one cycle later
   task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                         output int ncyc, output int nbusy, output bit timeout,
                         output logic done_next);
      applyStimulus(1'b1, f, x, y);
      ncyc    = 0;
      nbusy   = 0;
      timeout = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         ncyc++;
         if (busy) nbusy++;
         if (i == 0) applyStimulus(1'b0, SLL, 32'd0, 32'd0);
         if (done) begin
            timeout = 1'b0;
            break;
         end
      end
      @(negedge clk);
      done_next = done;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if ({hi, lo, busy, done, stall} !== 67'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b required all 0",
                  hi, lo, busy, done, stall);
      end
      reset = 1'b0;
   endtask

   task automatic test_op(input string name, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y);
      int ncyc;
      int nbusy;
      bit tmo;
      logic dn;
      logic [63:0] exp;
      int exp_cyc;
      exp     = ref_model(f, x, y);
      exp_cyc = (is_div(f) && y == 32'd0) ? 2 : 34;
      run_op(f, x, y, ncyc, nbusy, tmo, dn);
      compared++;
      if (tmo || ncyc != exp_cyc || nbusy != exp_cyc - 1) begin
         mismatched++;
         $display("[TB] FAIL %s_timing: got cycles=%0d busy=%0d timeout=%b required cycles=%0d busy=%0d",
                  name, ncyc, nbusy, tmo, exp_cyc, exp_cyc - 1);
      end
      compared++;
      if ({hi, lo} !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s_result: got hi=%h lo=%h required hi=%h lo=%h",
                  name, hi, lo, exp[63:32], exp[31:0]);
      end
      compared++;
      if (dn !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s_done_pulse: got done=%b one cycle later required 0", name, dn);
      end
   endtask

   task automatic test_directed;
      test_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      test_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd7);
      test_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2);
      test_op("divu_zero", DIVU, 32'd100, 32'd0);
      test_op("div_zero_neg", DIV, 32'hFFFFFF00, 32'd0);
      test_op("div_minint", DIV, 32'h80000000, 32'hFFFFFFFF);
      test_op("mult_minint", MULT, 32'h80000000, 32'h80000000);
   endtask

   task automatic test_stall;
      int stalls;
      applyStimulus(1'b1, MULT, 32'hFFFFFFFD, 32'd7);
      @(posedge clk);
      stalls = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == 10) applyStimulus(1'b1, ADDU, 32'd1, 32'd2);
         else applyStimulus(1'b1, MFLO, 32'd0, 32'd0);
         #1;
         if (k == 10) begin
            compared++;
            if (stall !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL addu_no_stall: got stall=%b required 0", stall);
            end
         end else if (stall === 1'b1) begin
            stalls++;
         end
      end
      compared++;
      if (stalls != 32) begin
         mismatched++;
         $display("[TB] FAIL mflo_stall_cycles: got %0d required 32", stalls);
      end
      @(negedge clk);
      #1;
      compared++;
      if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || lo !== 32'hFFFFFFEB
          || hi !== 32'hFFFFFFFF) begin
         mismatched++;
         $display("[TB] FAIL mflo_release: got stall=%b busy=%b done=%b hi=%h lo=%h required 0 0 1 ffffffff ffffffeb",
                  stall, busy, done, hi, lo);
      end
      applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      @(negedge clk);
   endtask

   task automatic test_mthi_mtlo;
      int stalls;
      applyStimulus(1'b1, MTHI, 32'h12345678, 32'd0);
      @(negedge clk);
      compared++;
      if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mthi_idle: got hi=%h busy=%b done=%b required 12345678 0 0",
                  hi, busy, done);
      end
      applyStimulus(1'b1, DIVU, 32'd1000, 32'd7);
      @(posedge clk);
      stalls = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == 1) applyStimulus(1'b0, SLL, 32'd0, 32'd0);
         if (k == 5) applyStimulus(1'b1, MTLO, 32'h0000CAFE, 32'd0);
         #1;
         if (stall === 1'b1) stalls++;
      end
      compared++;
      if (stalls != 29) begin
         mismatched++;
         $display("[TB] FAIL mtlo_stall_cycles: got %0d required 29", stalls);
      end
      @(negedge clk);
      compared++;
      if (stall !== 1'b0 || lo !== 32'd142 || hi !== 32'd6 || done !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL divu_before_mtlo: got stall=%b hi=%h lo=%h done=%b required 0 6 8e 1",
                  stall, hi, lo, done);
      end
      @(negedge clk);
      compared++;
      if (lo !== 32'h0000CAFE || hi !== 32'd6 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mtlo_after_run: got hi=%h lo=%h busy=%b required 6 cafe 0",
                  hi, lo, busy);
      end
      applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      int ncyc;
      int nbusy;
      bit tmo;
      logic dn;
      prev_hi = hi;
      prev_lo = lo;
      applyStimulus(1'b1, DIVU, 32'hFFFF0000, 32'd3);
      @(posedge clk);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      end
      compared++;
      if (hi !== prev_hi || lo !== prev_lo || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL hilo_hold_in_run: got hi=%h lo=%h busy=%b required %h %h 1",
                  hi, lo, busy, prev_hi, prev_lo);
      end
      reset = 1'b1;
      @(negedge clk);
      compared++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_abort: got hi=%h lo=%h busy=%b done=%b required 0 0 0 0",
                  hi, lo, busy, done);
      end
      applyStimulus(1'b1, MTHI, 32'h55555555, 32'd0);
      @(negedge clk);
      compared++;
      if (hi !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_over_mthi: got hi=%h required 0", hi);
      end
      applyStimulus(1'b1, MULTU, 32'd5, 32'd5);
      @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_over_accept: got busy=%b required 0", busy);
      end
      reset = 1'b0;
      applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      @(negedge clk);
      run_op(MULTU, 32'd6, 32'd7, ncyc, nbusy, tmo, dn);
      compared++;
      if (tmo || hi !== 32'd0 || lo !== 32'd42) begin
         mismatched++;
         $display("[TB] FAIL multu_after_reset: got hi=%h lo=%h timeout=%b required 0 2a 0",
                  hi, lo, tmo);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] x1;
      logic [31:0] y1;
      logic [31:0] x2;
      logic [31:0] y2;
      logic [63:0] exp1;
      logic [63:0] exp2;
      int k;
      x1 = $urandom;
      y1 = $urandom;
      x2 = $urandom;
      y2 = $urandom_range(1, 1000);
      exp1 = ref_model(MULT, x1, y1);
      exp2 = ref_model(DIVU, x2, y2);
      applyStimulus(1'b1, MULT, x1, y1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b1, DIVU, x2, y2);
      repeat (33) @(negedge clk);
      #1;
      compared++;
      if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || {hi, lo} !== exp1) begin
         mismatched++;
         $display("[TB] FAIL b2b_first: got stall=%b busy=%b done=%b hi=%h lo=%h required 0 0 1 %h %h",
                  stall, busy, done, hi, lo, exp1[63:32], exp1[31:0]);
      end
      @(negedge clk);
      compared++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_second_accept: got busy=%b done=%b required 1 0", busy, done);
      end
      applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      k = 35;
      while (done !== 1'b1 && k < 140) begin
         @(negedge clk);
         k++;
      end
      compared++;
      if (k != 68 || {hi, lo} !== exp2) begin
         mismatched++;
         $display("[TB] FAIL b2b_second: got done_at=%0d hi=%h lo=%h required 68 %h %h",
                  k, hi, lo, exp2[63:32], exp2[31:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [5:0]  f;
      logic [31:0] x;
      logic [31:0] y;
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0: f = MULT;
            1: f = MULTU;
            2: f = DIV;
            default: f = DIVU;
         endcase
         x = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1, 2: y = $urandom_range(1, 15);
            3: y = -$urandom_range(1, 15);
            default: y = $urandom;
         endcase
         test_op("random", f, x, y);
      end
   endtask

   // Scenario sequence; each task leaves the bench at a falling edge
   initial begin
      applyStimulus(1'b0, SLL, 32'd0, 32'd0);
      reset = 1'b1;
      test_reset();
      test_directed();
      test_stall();
      test_mthi_mtlo();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
